// File: rtl/serial_word_assembler_pkg.sv
// ---------------------------------------------------------------------------
// serial_word_assembler_pkg
//
// Purpose:
//   Shared constants and types for the serial word assembler and its
//   one-entry output buffer.
//
// Contents:
//   WORD_W       assembled word width (matches the decode stage input)
//   CNT_W        width of the per-word bit counter; 2**CNT_W must exceed WORD_W
//   buf_state_e  output buffer occupancy state
// ---------------------------------------------------------------------------
package serial_word_assembler_pkg;

  localparam int WORD_W = 6;
  localparam int CNT_W  = 3;

  // Occupancy of the one-entry output buffer; FULL is exactly data_valid.
  typedef enum logic {
    BUF_EMPTY = 1'b0,
    BUF_FULL  = 1'b1
  } buf_state_e;

endpackage : serial_word_assembler_pkg

// File: rtl/serial_word_assembler_holding_reg.sv
// ---------------------------------------------------------------------------
// word_holding_reg
//
// Purpose:
//   One-entry output buffer between the serial assembler and the downstream
//   combinational decode stage. Holds a finished word under a valid/ready
//   handshake and raises a sticky overflow flag when a finished word arrives
//   while the buffer is full and not being drained.
//
// Ports:
//   clk         system clock, rising edge
//   rst         synchronous, active-high reset
//   load        a finished word is presented this cycle
//   load_word   the finished word
//   data_ready  consumer accepts data_out this cycle
//   data_out    buffered word; changes only on a load or on reset
//   data_valid  buffer holds an unconsumed word
//   overflow    sticky; a finished word was dropped (cleared only by rst)
// ---------------------------------------------------------------------------
module word_holding_reg
  import serial_word_assembler_pkg::*;
#(
  parameter int WIDTH = WORD_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_word,
  input  logic             data_ready,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  output logic             overflow
);

  buf_state_e state_q;
  buf_state_e state_d;
  logic       capture;
  logic       set_overflow;

  // Next-state and buffer-control decode. A load into a full buffer is only
  // accepted when the current word leaves on the same edge, which gives
  // back-to-back words with no bubble; otherwise the new word is dropped and
  // overflow is flagged. data_ready while empty has no effect.
  always_comb begin
    state_d      = state_q;
    capture      = 1'b0;
    set_overflow = 1'b0;
    case (state_q)
      BUF_EMPTY: begin
        if (load) begin
          capture = 1'b1;
          state_d = BUF_FULL;
        end
      end
      BUF_FULL: begin
        if (load && data_ready) begin
          capture = 1'b1;
          state_d = BUF_FULL;
        end else if (load) begin
          set_overflow = 1'b1;
        end else if (data_ready) begin
          state_d = BUF_EMPTY;
        end
      end
      default: begin
        state_d = BUF_EMPTY;
      end
    endcase
  end

  // State, data and sticky flag registers. data_out is written only on a
  // capture so the decode stage never sees a transient word; draining the
  // buffer leaves the last word in place.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= BUF_EMPTY;
      data_out <= '0;
      overflow <= 1'b0;
    end else begin
      state_q <= state_d;
      if (capture) begin
        data_out <= load_word;
      end
      if (set_overflow) begin
        overflow <= 1'b1;
      end
    end
  end

  assign data_valid = (state_q == BUF_FULL);

endmodule : word_holding_reg

// File: rtl/serial_word_assembler.sv
// ---------------------------------------------------------------------------
// serial_word_assembler
//
// Purpose:
//   Collects a serial bit stream into WIDTH-bit words and hands each finished
//   word to a one-entry output buffer that feeds the decode stage's data_in.
//   A sync pulse restarts framing by discarding the partial word.
//
// Parameters:
//   WIDTH      word width in bits (decode stage input width)
//   MSB_FIRST  1: first received bit lands in data_out[WIDTH-1]
//              0: first received bit lands in data_out[0]
//
// Ports:
//   clk           system clock, rising edge
//   rst           synchronous, active-high reset; overrides all inputs
//   serial_in     serial data bit
//   serial_valid  serial_in is sampled on this edge
//   sync          framing restart; discards the partial word
//   data_out      assembled word
//   data_valid    data_out holds an unconsumed word
//   data_ready    consumer accepts data_out this cycle
//   overflow      sticky; a completed word was dropped
//   bit_count     bits received in the current partial word, 0..WIDTH-1
// ---------------------------------------------------------------------------
module serial_word_assembler
  import serial_word_assembler_pkg::*;
#(
  parameter int WIDTH     = WORD_W,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             serial_in,
  input  logic             serial_valid,
  input  logic             sync,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  input  logic             data_ready,
  output logic             overflow,
  output logic [CNT_W-1:0] bit_count
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

  logic [WIDTH-1:0] shreg_q;
  logic [WIDTH-1:0] shreg_d;
  logic [WIDTH-1:0] shifted;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             last_bit;
  logic             word_done;

  // Shift path and bit counter. sync outranks serial_valid, so a bit
  // presented together with sync is discarded and can never complete a word.
  // The shifted value is also the completed word on the final bit, which is
  // why it is handed to the buffer on the same edge.
  always_comb begin
    if (MSB_FIRST) begin
      shifted = {shreg_q[WIDTH-2:0], serial_in};
    end else begin
      shifted = {serial_in, shreg_q[WIDTH-1:1]};
    end

    last_bit  = (cnt_q == LAST_IDX);
    word_done = serial_valid && !sync && last_bit;

    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    if (sync) begin
      shreg_d = '0;
      cnt_d   = '0;
    end else if (serial_valid) begin
      shreg_d = shifted;
      cnt_d   = last_bit ? '0 : cnt_q + CNT_W'(1);
    end
  end

  // Partial-word state. Idle cycles (serial_valid=0) simply hold it.
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bit_count = cnt_q;

  word_holding_reg #(
    .WIDTH(WIDTH)
  ) u_holding_reg (
    .clk       (clk),
    .rst       (rst),
    .load      (word_done),
    .load_word (shifted),
    .data_ready(data_ready),
    .data_out  (data_out),
    .data_valid(data_valid),
    .overflow  (overflow)
  );

endmodule : serial_word_assembler
